// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: loads an 80-byte header, sweeps nonces on the miner, and reports the result.
// Define NONCE_DISPATCHER_HASH_REPORT_EN to append the 256-bit miner hash to success records.
module nonce_dispatcher #(
  parameter int unsigned ATTEMPT_CYCLES = 198,
  parameter logic [31:0] NONCE_START    = 32'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [639:0] block_header,
  output logic [31:0]  nonce,
  output logic         miner_reset,
  input  logic         miner_hash_success,
`ifdef NONCE_DISPATCHER_HASH_REPORT_EN
  input  logic [255:0] miner_hash,
`endif
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         found
);

  localparam int unsigned CntW = $clog2(ATTEMPT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(ATTEMPT_CYCLES - 1);
`ifdef NONCE_DISPATCHER_HASH_REPORT_EN
  localparam int unsigned RecBytes = 37;
`else
  localparam int unsigned RecBytes = 5;
`endif
  localparam int unsigned RecW = RecBytes * 8;
  localparam int unsigned IdxW = $clog2(RecBytes);

  typedef enum logic [2:0] {StLoad, StStart, StRun, StResync, StReport} state_e;

  state_e state_q, state_d;

  logic [6:0]      byte_cnt_q;
  logic [CntW-1:0] cyc_cnt_q;
  logic [RecW-1:0] rec_q;
  logic [IdxW-1:0] tx_idx_q, rec_last_q;
  logic [639:0]    header_q;
  logic [31:0]     nonce_q;
  logic [7:0]      tx_data_q;
  logic            rx_ready_q, miner_reset_q, tx_valid_q, busy_q, found_q;
  logic            rx_ready_d, miner_reset_d, tx_valid_d, busy_d;

  logic            rx_fire, tx_fire, tx_done, cyc_last;
  logic [RecW-1:0] rec_success, rec_exhaust;

  assign rx_fire  = rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & tx_ready;
  assign tx_done  = tx_fire && (tx_idx_q == rec_last_q);
  assign cyc_last = (cyc_cnt_q == CntLast);

  // Records are shifted out MSB byte first; the exhaust record only uses its top 5 bytes.
`ifdef NONCE_DISPATCHER_HASH_REPORT_EN
  assign rec_success = {8'hA5, nonce_q, miner_hash};
  assign rec_exhaust = {8'h5A, 32'hFFFF_FFFF, 256'h0};
`else
  assign rec_success = {8'hA5, nonce_q};
  assign rec_exhaust = {8'h5A, 32'hFFFF_FFFF};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (rx_fire && byte_cnt_q == 7'd79) state_d = StStart;
      StStart:  state_d = StRun;
      StRun: begin
        if (miner_hash_success) begin
          state_d = StReport;
        end else if (cyc_last) begin
          state_d = (nonce_q == 32'hFFFF_FFFF) ? StReport : StResync;
        end
      end
      StResync: state_d = StRun;
      StReport: if (tx_done) state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_comb begin
    rx_ready_d    = (state_d == StLoad);
    miner_reset_d = (state_d != StRun);
    tx_valid_d    = (state_d == StReport);
    busy_d        = (state_d == StStart) || (state_d == StRun) || (state_d == StResync);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt_q    <= '0;
      cyc_cnt_q     <= '0;
      rec_q         <= '0;
      tx_idx_q      <= '0;
      rec_last_q    <= '0;
      header_q      <= '0;
      nonce_q       <= NONCE_START;
      tx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      miner_reset_q <= 1'b1;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
    end else begin
      rx_ready_q    <= rx_ready_d;
      miner_reset_q <= miner_reset_d;
      tx_valid_q    <= tx_valid_d;
      busy_q        <= busy_d;

      if (rx_fire) begin
        header_q   <= {header_q[631:0], rx_data};
        byte_cnt_q <= (byte_cnt_q == 7'd79) ? 7'd0 : byte_cnt_q + 7'd1;
        if (byte_cnt_q == 7'd0) found_q <= 1'b0;
      end

      unique case (state_q)
        StStart: begin
          nonce_q   <= NONCE_START;
          cyc_cnt_q <= '0;
        end
        StResync: begin
          nonce_q   <= nonce_q + 32'd1;
          cyc_cnt_q <= '0;
        end
        StRun:   cyc_cnt_q <= cyc_cnt_q + CntW'(1);
        default: ;
      endcase

      if (state_q == StRun && state_d == StReport) begin
        tx_idx_q <= '0;
        if (miner_hash_success) begin
          found_q    <= 1'b1;
          rec_q      <= rec_success;
          rec_last_q <= IdxW'(RecBytes - 1);
          tx_data_q  <= 8'hA5;
        end else begin
          rec_q      <= rec_exhaust;
          rec_last_q <= IdxW'(4);
          tx_data_q  <= 8'h5A;
        end
      end else if (tx_fire && !tx_done) begin
        rec_q     <= rec_q << 8;
        tx_data_q <= rec_q[RecW-9 -: 8];
        tx_idx_q  <= tx_idx_q + IdxW'(1);
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign block_header = header_q;
  assign nonce        = nonce_q;
  assign miner_reset  = miner_reset_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;
  assign found        = found_q;

endmodule
